// File: rtl/wb_port_arbiter_if.sv
// Write-back request bundle between ALU/MEM/MDU sources and the register-file write stage.
// Latency: none (wiring only).
// Backpressure: each source holds valid/rd/data until its ready is seen high.
interface wb_port_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              alu_valid;
   logic [ADDR_W-1:0] alu_rd;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;

   logic              mem_valid;
   logic [ADDR_W-1:0] mem_rd;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ready;

   logic              mdu_valid;
   logic [ADDR_W-1:0] mdu_rd;
   logic [DATA_W-1:0] mdu_data;
   logic              mdu_ready;

   logic              RegWrite;
   logic [ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0] write_data;
   logic [1:0]        wb_src;

   // Requester side: drives the three request channels, observes readies and the write port.
   modport master (
      output alu_valid, alu_rd, alu_data,
      output mem_valid, mem_rd, mem_data,
      output mdu_valid, mdu_rd, mdu_data,
      input  alu_ready, mem_ready, mdu_ready,
      input  RegWrite, write_reg, write_data, wb_src
   );

   // Arbiter side: accepts requests and drives the registered register-file write port.
   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  mem_valid, mem_rd, mem_data,
      input  mdu_valid, mdu_rd, mdu_data,
      output alu_ready, mem_ready, mdu_ready,
      output RegWrite, write_reg, write_data, wb_src
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port among ALU, MEM and MDU (MEM > MDU > ALU, starvation-promoted ALU/MDU).
// Latency: grant in cycle k appears on RegWrite/write_reg/write_data/wb_src after edge k.
// Backpressure: one combinational ready per cycle; ungranted sources wait, all readies low during reset.
module wb_port_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   wb_port_arbiter_if.slave    bus
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   localparam logic [1:0] SRC_ALU = 2'b00;
   localparam logic [1:0] SRC_MEM = 2'b01;
   localparam logic [1:0] SRC_MDU = 2'b10;

   logic [CNT_W-1:0] alu_cnt;
   logic [CNT_W-1:0] mdu_cnt;
   logic             alu_starved;
   logic             mdu_starved;
   logic             gnt_alu;
   logic             gnt_mem;
   logic             gnt_mdu;

   assign alu_starved = (alu_cnt == CNT_MAX);
   assign mdu_starved = (mdu_cnt == CNT_MAX);

   // Grant selection: starved MDU, then starved ALU, then base order MEM > MDU > ALU; nothing during reset.
   always_comb begin
      gnt_alu = 1'b0;
      gnt_mem = 1'b0;
      gnt_mdu = 1'b0;
      if (!reset) begin
         if (bus.mdu_valid && mdu_starved) begin
            gnt_mdu = 1'b1;
         end else if (bus.alu_valid && alu_starved) begin
            gnt_alu = 1'b1;
         end else if (bus.mem_valid) begin
            gnt_mem = 1'b1;
         end else if (bus.mdu_valid) begin
            gnt_mdu = 1'b1;
         end else if (bus.alu_valid) begin
            gnt_alu = 1'b1;
         end
      end
   end

   assign bus.alu_ready = gnt_alu;
   assign bus.mem_ready = gnt_mem;
   assign bus.mdu_ready = gnt_mdu;

   // Starvation counters: count denied waiting cycles, saturate, clear on grant or when the request drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_cnt <= '0;
         mdu_cnt <= '0;
      end else begin
         if (!bus.alu_valid || gnt_alu)
            alu_cnt <= '0;
         else if (alu_cnt != CNT_MAX)
            alu_cnt <= alu_cnt + 1'b1;

         if (!bus.mdu_valid || gnt_mdu)
            mdu_cnt <= '0;
         else if (mdu_cnt != CNT_MAX)
            mdu_cnt <= mdu_cnt + 1'b1;
      end
   end

   // Registered write stage: capture the granted request; writes to r0 are consumed without asserting RegWrite.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.RegWrite   <= 1'b0;
         bus.write_reg  <= '0;
         bus.write_data <= '0;
         bus.wb_src     <= SRC_ALU;
      end else if (gnt_mem) begin
         bus.RegWrite   <= (bus.mem_rd != '0);
         bus.write_reg  <= bus.mem_rd;
         bus.write_data <= bus.mem_data;
         bus.wb_src     <= SRC_MEM;
      end else if (gnt_mdu) begin
         bus.RegWrite   <= (bus.mdu_rd != '0);
         bus.write_reg  <= bus.mdu_rd;
         bus.write_data <= bus.mdu_data;
         bus.wb_src     <= SRC_MDU;
      end else if (gnt_alu) begin
         bus.RegWrite   <= (bus.alu_rd != '0);
         bus.write_reg  <= bus.alu_rd;
         bus.write_data <= bus.alu_data;
         bus.wb_src     <= SRC_ALU;
      end else begin
         bus.RegWrite   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, single source, priority order, starvation, r0 writes, reset mid-grant.
// Latency: checks readies in the driving cycle and the write port one edge later.
// Backpressure: each request is dropped by the bench right after the edge at which it was granted.
module tb_wb_port_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ready(input string tag, input logic a, input logic m, input logic d);
      #1;
      chk({tag, " alu_ready"}, {31'd0, bus.alu_ready}, {31'd0, a});
      chk({tag, " mem_ready"}, {31'd0, bus.mem_ready}, {31'd0, m});
      chk({tag, " mdu_ready"}, {31'd0, bus.mdu_ready}, {31'd0, d});
   endtask

   task automatic chk_wr(input string tag, input logic we, input logic [4:0] rd,
                         input logic [31:0] dat, input logic [1:0] src);
      chk({tag, " RegWrite"},   {31'd0, bus.RegWrite}, {31'd0, we});
      chk({tag, " write_reg"},  {27'd0, bus.write_reg}, {27'd0, rd});
      chk({tag, " write_data"}, bus.write_data, dat);
      chk({tag, " wb_src"},     {30'd0, bus.wb_src}, {30'd0, src});
   endtask

   initial begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h0;
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd1; bus.mem_data = 32'h0;
      bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd2; bus.mdu_data = 32'h0;

      // 1: reset held two cycles with all sources requesting
      for (int i = 0; i < 2; i++) begin
         chk_ready("reset", 1'b0, 1'b0, 1'b0);
         step();
         chk_wr("reset", 1'b0, 5'd0, 32'h0, 2'b00);
      end
      reset = 1'b0;
      bus.alu_valid = 1'b0; bus.mem_valid = 1'b0; bus.mdu_valid = 1'b0;

      // 2: lone ALU request
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h12345678;
      chk_ready("alu_only", 1'b1, 1'b0, 1'b0);
      step();
      bus.alu_valid = 1'b0;
      chk_wr("alu_only", 1'b1, 5'd5, 32'h12345678, 2'b00);
      step();
      chk_wr("alu_only idle", 1'b0, 5'd5, 32'h12345678, 2'b00);

      // 3: all three valid, base priority MEM > MDU > ALU
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd1; bus.mem_data = 32'h87654321;
      bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd2; bus.mdu_data = 32'hAAAAAAAA;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hBBBBBBBB;
      chk_ready("prio c0", 1'b0, 1'b1, 1'b0);
      step();
      bus.mem_valid = 1'b0;
      chk_wr("prio w1", 1'b1, 5'd1, 32'h87654321, 2'b01);
      chk_ready("prio c1", 1'b0, 1'b0, 1'b1);
      step();
      bus.mdu_valid = 1'b0;
      chk_wr("prio w2", 1'b1, 5'd2, 32'hAAAAAAAA, 2'b10);
      chk_ready("prio c2", 1'b1, 1'b0, 1'b0);
      step();
      bus.alu_valid = 1'b0;
      chk_wr("prio w3", 1'b1, 5'd3, 32'hBBBBBBBB, 2'b00);

      // 4: MEM streaming starves ALU; ALU promoted after four denied cycles
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77777777;
      for (int i = 0; i < 4; i++) begin
         bus.mem_valid = 1'b1; bus.mem_rd = 5'(10 + i); bus.mem_data = 32'h100 + i;
         chk_ready("starve mem", 1'b0, 1'b1, 1'b0);
         step();
         chk_wr("starve mem w", 1'b1, 5'(10 + i), 32'h100 + i, 2'b01);
      end
      bus.mem_rd = 5'd14; bus.mem_data = 32'h104;
      chk_ready("starve alu", 1'b1, 1'b0, 1'b0);
      step();
      bus.alu_valid = 1'b0;
      chk_wr("starve alu w", 1'b1, 5'd7, 32'h77777777, 2'b00);
      chk_ready("starve mem resume", 1'b0, 1'b1, 1'b0);
      step();
      bus.mem_valid = 1'b0;
      chk_wr("starve mem resume w", 1'b1, 5'd14, 32'h104, 2'b01);

      // 5: write to r0 is consumed but suppressed
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'hFFFFFFFF;
      chk_ready("r0", 1'b0, 1'b1, 1'b0);
      step();
      bus.mem_valid = 1'b0;
      chk_wr("r0 w", 1'b0, 5'd0, 32'hFFFFFFFF, 2'b01);

      // 6: reset coincides with an MDU request
      bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd9; bus.mdu_data = 32'h99999999;
      reset = 1'b1;
      chk_ready("rst mid", 1'b0, 1'b0, 1'b0);
      step();
      chk({"rst mid", " RegWrite"}, {31'd0, bus.RegWrite}, 32'd0);
      reset = 1'b0;
      chk_ready("rst after", 1'b0, 1'b0, 1'b1);
      step();
      bus.mdu_valid = 1'b0;
      chk_wr("rst after w", 1'b1, 5'd9, 32'h99999999, 2'b10);

      // 7: both ALU and MDU starved -> MDU first, ALU next cycle
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h33333333;
      bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd4; bus.mdu_data = 32'h44444444;
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd20; bus.mem_data = 32'h20202020;
      for (int i = 0; i < 4; i++) begin
         chk_ready("both mem", 1'b0, 1'b1, 1'b0);
         step();
      end
      chk_ready("both mdu", 1'b0, 1'b0, 1'b1);
      step();
      bus.mdu_valid = 1'b0;
      chk_wr("both mdu w", 1'b1, 5'd4, 32'h44444444, 2'b10);
      chk_ready("both alu", 1'b1, 1'b0, 1'b0);
      step();
      bus.alu_valid = 1'b0;
      chk_wr("both alu w", 1'b1, 5'd3, 32'h33333333, 2'b00);
      chk_ready("both mem resume", 1'b0, 1'b1, 1'b0);
      bus.mem_valid = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
